filtro_chaves_io: RTL

FILTRO_CHAVES_IO -- requirements
Module: filtro_chaves_io

---
 rtl/filtro_chaves_io.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/filtro_chaves_io.sv
// Multi-channel switch conditioner: 2-flop synchronizer, counting debouncer,
// and a registered output stage with press, release, level and auto-repeat modes.
module filtro_chaves_io #(
  parameter int N_CH      = 4,
  parameter int DEB_CYC   = 4,
  parameter int REP_DELAY = 10,
  parameter int REP_CYC   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] switch,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] saida,
  output logic [N_CH-1:0] estavel
);

  localparam int DW      = $clog2(DEB_CYC) + 1;
  localparam int REP_MAX = (REP_DELAY > REP_CYC) ? REP_DELAY : REP_CYC;
  localparam int RW      = $clog2(REP_MAX) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] CYC_LAST   = RW'(REP_CYC - 1);

  localparam logic [1:0] MODE_PRESS   = 2'd0;
  localparam logic [1:0] MODE_RELEASE = 2'd1;
  localparam logic [1:0] MODE_LEVEL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= switch;
      sync_s    <= sync_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
      logic          est_reg, est_next;
      logic          press_ev, release_ev;
      rep_state_t    rep_state_reg, rep_state_next;
      logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
      logic          rep_pulse;
      logic          saida_reg, saida_next;

      // Any sample equal to the accepted level restarts the count, so glitches
      // shorter than DEB_CYC samples never reach the terminal count.
      always_comb begin
        deb_cnt_next = '0;
        est_next     = est_reg;
        if (sync_s[gi] != est_reg) begin
          if (deb_cnt_reg == DEB_LAST) begin
            est_next = sync_s[gi];
          end else begin
            deb_cnt_next = deb_cnt_reg + DW'(1);
          end
        end
      end

      assign press_ev   = est_next & ~est_reg;
      assign release_ev = ~est_next & est_reg;

      // Repeat timer runs only while held in mode 3; leaving either condition
      // drops straight back to IDLE without a final pulse.
      always_comb begin
        rep_state_next = rep_state_reg;
        rep_cnt_next   = rep_cnt_reg;
        rep_pulse      = 1'b0;
        if ((mode != 2'd3) || !est_next) begin
          rep_state_next = IDLE;
          rep_cnt_next   = '0;
        end else begin
          case (rep_state_reg)
            IDLE: begin
              if (press_ev) begin
                rep_state_next = FIRST;
                rep_cnt_next   = '0;
              end
            end
            FIRST: begin
              if (rep_cnt_reg == DELAY_LAST) begin
                rep_state_next = REPEAT;
                rep_cnt_next   = '0;
                rep_pulse      = 1'b1;
              end else begin
                rep_cnt_next = rep_cnt_reg + RW'(1);
              end
            end
            REPEAT: begin
              if (rep_cnt_reg == CYC_LAST) begin
                rep_cnt_next = '0;
                rep_pulse    = 1'b1;
              end else begin
                rep_cnt_next = rep_cnt_reg + RW'(1);
              end
            end
            default: begin
              rep_state_next = IDLE;
              rep_cnt_next   = '0;
            end
          endcase
        end
      end

      always_comb begin
        saida_next = 1'b0;
        case (mode)
          MODE_PRESS:   saida_next = press_ev;
          MODE_RELEASE: saida_next = release_ev;
          MODE_LEVEL:   saida_next = est_next;
          default:      saida_next = press_ev | rep_pulse;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          deb_cnt_reg   <= '0;
          est_reg       <= 1'b0;
          rep_state_reg <= IDLE;
          rep_cnt_reg   <= '0;
          saida_reg     <= 1'b0;
        end else begin
          deb_cnt_reg   <= deb_cnt_next;
          est_reg       <= est_next;
          rep_state_reg <= rep_state_next;
          rep_cnt_reg   <= rep_cnt_next;
          saida_reg     <= saida_next;
        end
      end

      assign estavel[gi] = est_reg;
      assign saida[gi]   = saida_reg;
    end
  endgenerate

endmodule
